// File: rtl/key_conditioner.sv
// Five-button front end: 2-flop sync, per-key debounce, one-key-at-a-time
// acceptance with single-cycle press pulses and Up/Down auto-repeat.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_RATE     = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       Left,
    output logic       Right,
    output logic       Enter,
    output logic       Up,
    output logic       Down,
    output logic [2:0] Held
);

    localparam int NK = 5;
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    // Bit order of every key vector: 0 Left, 1 Right, 2 Enter, 3 Up, 4 Down.
    localparam logic [NK-1:0] REPEAT_KEYS = 5'b11000;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;

    logic [NK-1:0]    raw, sync1, sync2, db, db_prev, rise;
    logic [CNT_W-1:0] db_cnt [NK];

    assign raw = {btn_down, btn_up, btn_enter, btn_right, btn_left};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the sync chain.
    // NOTE: the debounce counter array is reset explicitly; a stale count
    // surviving reset would shorten the first debounce after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int k = 0; k < NK; k++) db_cnt[k] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int k = 0; k < NK; k++) begin
                if (sync2[k] != db[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        db[k]     <= ~db[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    assign rise = db & ~db_prev;

    state_t           state, state_n;
    logic [NK-1:0]    held_mask, held_mask_n, pulse, pulse_n, pick;
    logic [2:0]       held_n, pick_code;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;

    // Acceptance priority: Enter > Left > Right > Up > Down.
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pick      = '0;
        pick_code = 3'd0;
        if (rise[2]) begin
            pick[2] = 1'b1; pick_code = 3'd3;
        end else if (rise[0]) begin
            pick[0] = 1'b1; pick_code = 3'd1;
        end else if (rise[1]) begin
            pick[1] = 1'b1; pick_code = 3'd2;
        end else if (rise[3]) begin
            pick[3] = 1'b1; pick_code = 3'd4;
        end else if (rise[4]) begin
            pick[4] = 1'b1; pick_code = 3'd5;
        end
    end

    always_comb begin
        state_n     = state;
        held_mask_n = held_mask;
        held_n      = Held;
        rep_cnt_n   = rep_cnt;
        pulse_n     = '0;
        case (state)
            S_IDLE: begin
                if (|pick) begin
                    pulse_n     = pick;
                    held_mask_n = pick;
                    held_n      = pick_code;
                    rep_cnt_n   = '0;
                    state_n     = S_HELD;
                end
            end
            S_HELD, S_REPEAT: begin
                if ((db & held_mask) == '0) begin
                    held_mask_n = '0;
                    held_n      = 3'd0;
                    rep_cnt_n   = '0;
                    state_n     = S_IDLE;
                end else if (|(held_mask & REPEAT_KEYS)) begin
                    if (rep_cnt == ((state == S_HELD) ? DELAY_LAST : RATE_LAST)) begin
                        pulse_n   = held_mask;
                        rep_cnt_n = '0;
                        state_n   = S_REPEAT;
                    end else begin
                        rep_cnt_n = rep_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            held_mask <= '0;
            Held      <= 3'd0;
            rep_cnt   <= '0;
            pulse     <= '0;
        end else begin
            state     <= state_n;
            held_mask <= held_mask_n;
            Held      <= held_n;
            rep_cnt   <= rep_cnt_n;
            pulse     <= pulse_n;
        end
    end

    assign {Down, Up, Enter, Right, Left} = pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a per-cycle reference model queues
// expected outputs; a negedge monitor pops and compares.
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn = '0;
    logic       Left, Right, Enter, Up, Down;
    logic [2:0] Held;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_left (btn[0]),
        .btn_right(btn[1]),
        .btn_enter(btn[2]),
        .btn_up   (btn[3]),
        .btn_down (btn[4]),
        .Left     (Left),
        .Right    (Right),
        .Enter    (Enter),
        .Up       (Up),
        .Down     (Down),
        .Held     (Held)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Reference model: debounced level = synced input once it has disagreed
    // for DEB consecutive cycles; accepted key repeats at ages RD, RD+RR, ...
    bit [4:0] m_h1, m_h2, m_db, m_dbp;
    int       m_run [5];
    int       m_held;
    int       m_age;

    always @(posedge clk) begin : model
        logic [4:0] p;
        logic [4:0] rise_m;
        int         k_sel;
        p = '0;
        if (!rst) begin
            m_h1 = '0; m_h2 = '0; m_db = '0; m_dbp = '0;
            for (int k = 0; k < 5; k++) m_run[k] = 0;
            m_held = 0;
            m_age  = 0;
        end else begin
            rise_m = m_db & ~m_dbp;
            if (m_held == 0) begin
                k_sel = -1;
                if      (rise_m[2]) k_sel = 2;
                else if (rise_m[0]) k_sel = 0;
                else if (rise_m[1]) k_sel = 1;
                else if (rise_m[3]) k_sel = 3;
                else if (rise_m[4]) k_sel = 4;
                if (k_sel >= 0) begin
                    p[k_sel] = 1'b1;
                    m_held   = k_sel + 1;
                    m_age    = 0;
                end
            end else if (!m_db[m_held-1]) begin
                m_held = 0;
            end else begin
                m_age++;
                if (m_held >= 4 && (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0)))
                    p[m_held-1] = 1'b1;
            end
            m_dbp = m_db;
            for (int k = 0; k < 5; k++) begin
                if (m_h2[k] != m_db[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_db[k]  = ~m_db[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = btn;
        end
        exp_q.push_back({3'(m_held), p});
    end

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", {Held, Down, Up, Enter, Right, Left}, e);
            check("exclusive", 8'($countones({Down, Up, Enter, Right, Left}) <= 1), 8'd1);
        end
    end

    task automatic hold(input logic [4:0] v, input int n);
        repeat (n) begin
            @(negedge clk);
            btn = v;
        end
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int found;
        int cnt;
        logic [4:0] v;
        logic [4:0] extra;
        rst = 1'b0;
        btn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(5'b00000, 5);

        // Bounce on Right, then stable high, then release.
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 5'b00010 : 5'b00000, 2);
        hold(5'b00010, 20);
        hold(5'b00000, 12);

        // Short glitch on Enter.
        hold(5'b00100, 3);
        hold(5'b00000, 12);

        // Auto-repeat on Up: count pulses over 60 cycles from the first one.
        hold(5'b01000, 1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (Up) found = 1;
        end
        check("up_first_pulse_seen", 8'(found), 8'd1);
        cnt = found;
        repeat (59) begin
            @(negedge clk);
            if (Up) cnt++;
        end
        check("up_repeat_count", 8'(cnt), 8'd6);
        hold(5'b00000, 15);

        // Lockout: Enter held, Left joins, Enter released, Left re-pressed.
        hold(5'b00100, 10);
        hold(5'b00101, 15);
        hold(5'b00001, 20);
        hold(5'b00000, 10);
        hold(5'b00001, 15);
        hold(5'b00000, 10);

        // Simultaneous Left and Right.
        hold(5'b00011, 20);
        hold(5'b00000, 10);

        // Reset while Down is repeating.
        hold(5'b10000, 40);
        reset_pulse(2);
        hold(5'b10000, 50);
        hold(5'b00000, 12);

        // Randomized episodes: bounces, chords, late foreign keys, resets.
        for (int ep = 0; ep < 40; ep++) begin
            v = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) v |= 5'(1 << $urandom_range(0, 4));
            repeat ($urandom_range(0, 6)) begin
                @(negedge clk);
                btn = ($urandom_range(0, 1) == 1) ? v : 5'b00000;
            end
            hold(v, $urandom_range(1, 50));
            if ($urandom_range(0, 2) == 0) begin
                extra = 5'(1 << $urandom_range(0, 4));
                hold(v | extra, $urandom_range(1, 20));
            end
            if ($urandom_range(0, 7) == 0) reset_pulse($urandom_range(1, 2));
            hold(5'b00000, $urandom_range(1, 15));
        end

        hold(5'b00000, 20);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end button conditioner that sits directly upstream of the Input menu block.
- Synchronises and debounces five raw push-buttons and emits clean one-cycle press pulses on Left/Right/Enter/Up/Down.
- Enforces a one-key-at-a-time rule and provides auto-repeat on Up/Down, so holding a key scrolls Value.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive cycles a synchronised input must differ from its debounced state before the state flips (min 2)
REPEAT_DELAY, 5000000, cycles from the initial Up/Down pulse to the first repeat pulse (min 2)
REPEAT_RATE, 1000000, cycles between subsequent repeat pulses (min 2)
CNT_W, 24, width of the internal debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous active-low reset
btn_left  input  1  raw button, active-high, asynchronous, bouncy
btn_right  input  1  raw button
btn_enter  input  1  raw button
btn_up  input  1  raw button
btn_down  input  1  raw button
Left  output  1  one-cycle press pulse, registered
Right  output  1  one-cycle press pulse, registered
Enter  output  1  one-cycle press pulse, registered
Up  output  1  one-cycle press/repeat pulse, registered
Down  output  1  one-cycle press/repeat pulse, registered
Held  output  3  code of the accepted key still held: 0 none, 1 Left, 2 Right, 3 Enter, 4 Up, 5 Down

Behaviour:
- Reset (rst==0 at a rising edge):
  - All outputs go to 0.
  - Sync flops, debounced states and all counters clear.
  - FSM returns to IDLE.
  - rst overrides everything, including mid-repeat.
- Synchroniser: 2-flop chain per button.
- Debounce, per key:
  - If sync differs from the debounced state db, the counter increments. Otherwise the counter clears.
  - When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, db toggles and the counter clears.
  - Any single cycle of agreement restarts the count.
- Rising-edge detect: rise_k = db_k & ~db_k_prev.
- Latency: let E0 be the first edge sampling raw high, held stable thereafter. db rises at E0+DEBOUNCE_CYCLES+1, and the pulse is high for exactly one cycle after edge E0+DEBOUNCE_CYCLES+2.
- FSM states IDLE, HELD, REPEAT:
  - IDLE:
    - If any rise_k is set, accept exactly one key by priority Enter > Left > Right > Up > Down.
    - Register a pulse on that output, load Held with the key code, and go to HELD.
    - Rising edges on the other keys in the same cycle are discarded.
  - HELD:
    - On db of the held key = 0: Held <= 0, go to IDLE.
    - Else, for Up/Down only: count cycles from the initial pulse. When the count reaches REPEAT_DELAY, emit a pulse, clear the counter and go to REPEAT.
    - Left/Right/Enter never repeat.
  - REPEAT:
    - On release: go to IDLE, Held <= 0.
    - Else emit a pulse every REPEAT_RATE cycles.
- Foreign presses:
  - Rising edges of other keys while in HELD/REPEAT are ignored permanently.
  - Such a key must be released and re-pressed after returning to IDLE to be accepted.
- Output exclusivity: at most one of Left/Right/Enter/Up/Down is high in any cycle, always a single-cycle pulse.
- Release and re-press: a release followed by a new debounced rise in the same key is a new press. The earliest pulse is one cycle after the IDLE return edge.
- Button held through reset: db restarts at 0, so after reset release the held key is debounced afresh and yields one press pulse DEBOUNCE_CYCLES+2 edges later. This is required behaviour.
- Counter saturation: counters never wrap; comparisons use ==.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, 10 ns clk; rst low 3 cycles, then high.
1. Bounce: btn_right toggles every 2 cycles for 12 cycles, then stays high 20 cycles -> exactly one Right pulse, 6 edges after the stable-high start edge; Held=2 while high, 0 after release is debounced.
2. Glitch: btn_enter high 3 cycles then low -> no pulse on any output, Held stays 0.
3. Auto-repeat: btn_up held 60 cycles past its first pulse (t=0) -> Up pulses at t=0, 20, 28, 36, 44, 52; Held=4 throughout; no Up pulse after release, Held=0.
4. Lockout: btn_enter pressed, then btn_left pressed 10 cycles later, then Enter released while Left stays held -> only one Enter pulse, no Left pulse; Left released and re-pressed -> one Left pulse.
5. Simultaneous: btn_left and btn_right rise on the same edge, both held 20 cycles -> single Left pulse, Held=1, no Right pulse.
6. Reset mid-repeat: btn_down held into REPEAT, rst low for 2 cycles while still held -> all outputs 0 during reset; after release of rst, one Down pulse 6 edges later, then repeats resume per REPEAT_DELAY/REPEAT_RATE.
